riscv_data_arbiter: RTL and testbench
=====================================

Name: riscv_data_arbiter

Overview:
- Two-master, one-slave arbiter for the data-memory port: ext_mem sits behind it, core LSU is master 0, a second requester (DMA/debug) is master 1.
- Grants round-robin, registers the winner's request fields, and holds the grant until ext_mem returns ready or a timeout fires.
- Sits between LSU/DMA and ext_mem in the top level, on the sysclk domain.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in BUSY without mem_ready_i before error completion; 0 disables timeout
CNT_W, 8, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk_i  in  1  system clock (sysclk)
rst_i  in  1  synchronous reset, active-high
m0_req_i  in  1  master 0 request, held until m0_ready_o
m0_we_i  in  1  master 0 write enable
m0_be_i  in  4  master 0 byte enables
m0_addr_i  in  32  master 0 address
m0_wd_i  in  32  master 0 write data
m0_rd_o  out  32  master 0 read data, valid with m0_ready_o
m0_ready_o  out  1  master 0 completion pulse
m0_err_o  out  1  master 0 timeout-error pulse, coincident with m0_ready_o
m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wd_i  in  1/1/4/32/32  master 1, same as m0
m1_rd_o, m1_ready_o, m1_err_o  out  32/1/1  master 1, same as m0
mem_req_o  out  1  request to ext_mem
mem_we_o  out  1  write enable to ext_mem
mem_be_o  out  4  byte enables to ext_mem
mem_addr_o  out  32  address to ext_mem
mem_wd_o  out  32  write data to ext_mem
mem_rd_i  in  32  read data from ext_mem
mem_ready_i  in  1  ext_mem completion

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: state=IDLE, grant=0, last_grant=1 (M0 wins first tie), timeout counter=0, latched we/be/addr/wd=0.
  - All outputs 0 during and after reset until the first grant: mem_*, m*_ready_o, m*_err_o, and m*_rd_o (forced 0 in IDLE).
- States: IDLE, BUSY.
- IDLE: mem_req_o=0.
  - Only one master requesting: that master wins.
  - Both requesting: the master != last_grant wins.
  - On the edge the winner is chosen: grant<=winner, latch winner's we/be/addr/wd, counter<=0, go to BUSY.
- BUSY: mem_req_o=1; mem_we/be/addr/wd_o driven from the latched registers, stable for the whole transaction.
  - mem_ready_i=1: granted master's ready_o=1 in the same cycle (combinational from mem_ready_i). Its rd_o=mem_rd_i. last_grant<=grant; go to IDLE.
  - mem_ready_i=0 and TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: granted master's ready_o=1 and err_o=1, rd_o=32'h0. last_grant<=grant; go to IDLE.
  - Otherwise: counter<=counter+1.
- Non-granted master: ready_o=0, err_o=0, rd_o=0 at all times.
- Latency: request seen in cycle N, mem_req_o in cycle N+1. With a zero-wait ext_mem, ready_o also pulses in N+1.
  - One IDLE cycle always separates transactions; maximum throughput is 1 transaction per 2 cycles.
- Masters deassert or change req on the edge after their ready_o.
  - If the winner drops req while in BUSY, the latched transaction still completes and ready_o still pulses.
- Requests from the loser are held pending, not lost.
  - Both masters requesting continuously alternate strictly: M0, M1, M0, ...
- mem_ready_i while IDLE: ignored, no ready_o pulse.
- Reset asserted in BUSY: IDLE on the next edge, mem_req_o=0, no ready_o pulse. A new transaction starts only after rst_i falls.
- Timeout and mem_ready_i on the same cycle: the normal completion wins, err_o=0.

Test Plan:
- Reset, then M0 single write (be=4'hF, addr=0x0000_0010, wd=0xCAFE_F00D), ext_mem ready one cycle after mem_req_o -> mem_* match, m0_ready_o one-cycle pulse, m1 outputs 0, readback via M0 read returns 0xCAFE_F00D on m0_rd_o.
- M0 and M1 both request continuously with 4 reads each -> grant order M0,M1,M0,M1,... and mem_req_o low exactly one cycle between transactions.
- M1 alone requests, then M0 and M1 tie -> M0 wins the tie (last_grant=1).
- TIMEOUT_CYCLES=8, ext_mem never ready -> after 8 BUSY cycles granted ready_o=1, err_o=1, rd_o=0; next request is served normally.
- rst_i pulsed on the 2nd BUSY cycle -> mem_req_o=0 next cycle, no ready_o pulse, last_grant=1.
- M1 holds req while M0 is in BUSY; M0 addr_i changes mid-BUSY -> mem_addr_o keeps the latched value; M1 is granted after M0 completes.

Source files
------------

// File: rtl/riscv_data_arbiter.sv
// rtl/riscv_data_arbiter.sv - two-master round-robin arbiter for the data-memory port
// Latches the winner's request and holds the grant until ext_mem completes or the timeout fires.
module riscv_data_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_wd_i,
    output logic [31:0] m0_rd_o,
    output logic        m0_ready_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_wd_i,
    output logic [31:0] m1_rd_o,
    output logic        m1_ready_o,
    output logic        m1_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state, state_nxt;
    logic              grant, last_grant, winner, any_req;
    logic              timeout_hit, complete;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [3:0]        lat_be;
    logic [31:0]       lat_addr, lat_wd;

    // A lone requester wins; on a tie the master that did not go last wins.
    always_comb begin
        any_req = m0_req_i | m1_req_i;
        if (m0_req_i && m1_req_i) winner = ~last_grant;
        else                      winner = m1_req_i;
    end

    // Normal completion takes priority over a coincident timeout.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST) && !mem_ready_i;
    assign complete    = (state == BUSY) && !rst_i && (mem_ready_i || timeout_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_be     <= '0;
            lat_addr   <= '0;
            lat_wd     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (any_req) begin
                    grant    <= winner;
                    cnt      <= '0;
                    lat_we   <= winner ? m1_we_i   : m0_we_i;
                    lat_be   <= winner ? m1_be_i   : m0_be_i;
                    lat_addr <= winner ? m1_addr_i : m0_addr_i;
                    lat_wd   <= winner ? m1_wd_i   : m0_wd_i;
                end
            end else if (complete) begin
                last_grant <= grant;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are gated by rst_i so a reset in BUSY never leaks a request or completion.
    always_comb begin
        state_nxt  = state;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        mem_be_o   = '0;
        mem_addr_o = '0;
        mem_wd_o   = '0;
        m0_ready_o = 1'b0;
        m0_err_o   = 1'b0;
        m0_rd_o    = '0;
        m1_ready_o = 1'b0;
        m1_err_o   = 1'b0;
        m1_rd_o    = '0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = BUSY;
            end
            BUSY: begin
                if (!rst_i) begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = lat_we;
                    mem_be_o   = lat_be;
                    mem_addr_o = lat_addr;
                    mem_wd_o   = lat_wd;
                    if (complete) begin
                        state_nxt = IDLE;
                        if (grant) begin
                            m1_ready_o = 1'b1;
                            m1_err_o   = !mem_ready_i;
                            m1_rd_o    = mem_ready_i ? mem_rd_i : 32'h0;
                        end else begin
                            m0_ready_o = 1'b1;
                            m0_err_o   = !mem_ready_i;
                            m0_rd_o    = mem_ready_i ? mem_rd_i : 32'h0;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_riscv_data_arbiter.sv
// tb/tb_riscv_data_arbiter.sv - scoreboard bench for riscv_data_arbiter
module tb_riscv_data_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 0, m0_we_i = 0, m1_req_i = 0, m1_we_i = 0;
    logic [3:0]  m0_be_i = 0, m1_be_i = 0;
    logic [31:0] m0_addr_i = 0, m0_wd_i = 0, m1_addr_i = 0, m1_wd_i = 0;
    logic [31:0] m0_rd_o, m1_rd_o;
    logic        m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o;
    logic [31:0] mem_rd_i = 0;
    logic        mem_ready_i = 0;

    riscv_data_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wd_i(m0_wd_i), .m0_rd_o(m0_rd_o), .m0_ready_o(m0_ready_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wd_i(m1_wd_i), .m1_rd_o(m1_rd_o), .m1_ready_o(m1_ready_o), .m1_err_o(m1_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
        .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          len;
    } exp_t;

    exp_t        q0[$], q1[$];
    int          order[$];
    int          n_chk = 0, n_fail = 0;
    bit          mem_hang = 0;
    int          mem_wait = 1;
    logic [31:0] mem [logic [31:0]];
    int          busy_len = 0, low_run = 0;
    bit          prev_req = 0, chk_gap = 0, gap_armed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ext_mem model: ready after mem_wait cycles of mem_req_o; unwritten words read as ~addr
    initial begin
        logic [31:0] a, d;
        int          wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk);
            if (mem_req_o && !mem_ready_i && !mem_hang) begin
                if (wcnt + 1 >= mem_wait) begin
                    wcnt = 0;
                    a = mem_addr_o;
                    d = mem.exists(a) ? mem[a] : ~a;
                    mem_ready_i <= 1'b1;
                    if (mem_we_o) begin
                        if (!mem.exists(a)) d = 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (mem_be_o[b]) d[8*b +: 8] = mem_wd_o[8*b +: 8];
                        mem[a] = d;
                        mem_rd_i <= 32'h0;
                    end else begin
                        mem_rd_i <= d;
                    end
                end else begin
                    wcnt++;
                end
            end else begin
                mem_ready_i <= 1'b0;
                mem_rd_i    <= 32'h0;
                if (!mem_req_o) wcnt = 0;
            end
        end
    end

    task automatic check_ready(input int m);
        exp_t e;
        order.push_back(m);
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_ready: master %0d got ready with empty queue", m);
            return;
        end
        if (m == 0) begin
            e = q0.pop_front();
            check("m0_rd", m0_rd_o, e.rd);
            check("m0_err", {31'h0, m0_err_o}, {31'h0, e.err});
            check("m1_idle_ready", {31'h0, m1_ready_o}, 32'h0);
            check("m1_idle_rd", m1_rd_o, 32'h0);
        end else begin
            e = q1.pop_front();
            check("m1_rd", m1_rd_o, e.rd);
            check("m1_err", {31'h0, m1_err_o}, {31'h0, e.err});
            check("m0_idle_ready", {31'h0, m0_ready_o}, 32'h0);
            check("m0_idle_rd", m0_rd_o, 32'h0);
        end
        if (e.len != 0) check("busy_len", 32'(busy_len), 32'(e.len));
    endtask

    // Monitor: pops the scoreboard on every completion and watches idle gaps between requests
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req_o) busy_len++;
            if (mem_req_o && !prev_req) begin
                if (chk_gap && gap_armed) check("idle_gap", 32'(low_run), 32'd1);
                gap_armed = chk_gap;
            end
            low_run  = mem_req_o ? 0 : low_run + 1;
            prev_req = mem_req_o;
            if (m0_ready_o) check_ready(0);
            if (m1_ready_o) check_ready(1);
            if (m0_ready_o || m1_ready_o || !mem_req_o) busy_len = 0;
        end
    end

    task automatic xfer(input int m, input logic we, input logic [3:0] be, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_len, input logic drop);
        exp_t e;
        bit   done;
        e.rd = exp_rd;
        e.err = exp_err;
        e.len = exp_len;
        if (m == 0) begin
            q0.push_back(e);
            m0_req_i = 1; m0_we_i = we; m0_be_i = be; m0_addr_i = addr; m0_wd_i = wd;
        end else begin
            q1.push_back(e);
            m1_req_i = 1; m1_we_i = we; m1_be_i = be; m1_addr_i = addr; m1_wd_i = wd;
        end
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = (m == 0) ? m0_ready_o : m1_ready_o;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL xfer_timeout: master %0d addr %h no ready within 200 cycles", m, addr);
        end
        cyc();
        if (drop) begin
            if (m == 0) m0_req_i = 0;
            else        m1_req_i = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_m0_ready", {31'h0, m0_ready_o}, 32'h0);
        check("rst_m1_err", {31'h0, m1_err_o}, 32'h0);
        check("rst_m0_rd", m0_rd_o, 32'h0);
        cyc();
        rst_i = 0;
        cyc();

        // M0 write then readback; check mem_* in the first BUSY cycle
        fork
            xfer(0, 1'b1, 4'hF, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b0, 2, 1'b1);
            begin
                @(negedge clk);
                @(negedge clk);
                check("wr_mem_req", {31'h0, mem_req_o}, 32'h1);
                check("wr_mem_we", {31'h0, mem_we_o}, 32'h1);
                check("wr_mem_be", {28'h0, mem_be_o}, 32'hF);
                check("wr_mem_addr", mem_addr_o, 32'h0000_0010);
                check("wr_mem_wd", mem_wd_o, 32'hCAFE_F00D);
            end
        join
        xfer(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1'b1);

        // M1 alone, then continuous tie: strict alternation starting with M0
        xfer(1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'hFFFF_FCFF, 1'b0, 2, 1'b1);
        order.delete();
        chk_gap = 1;
        fork
            for (int i = 0; i < 4; i++)
                xfer(0, 1'b0, 4'hF, 32'h100 + 32'(4*i), 32'h0, ~(32'h100 + 32'(4*i)), 1'b0, 2, i == 3);
            for (int i = 0; i < 4; i++)
                xfer(1, 1'b0, 4'hF, 32'h200 + 32'(4*i), 32'h0, ~(32'h200 + 32'(4*i)), 1'b0, 2, i == 3);
        join
        chk_gap = 0;
        check("alt_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < order.size(); i++) check("alt_order", 32'(order[i]), 32'(i % 2));

        // Timeout: ext_mem never ready, error completion after 8 BUSY cycles, then normal service
        mem_hang = 1;
        xfer(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h0, 1'b1, 8, 1'b1);
        mem_hang = 0;
        xfer(1, 1'b0, 4'hF, 32'h0000_0024, 32'h0, 32'hFFFF_FFDB, 1'b0, 2, 1'b1);

        // Reset pulsed on the 2nd BUSY cycle of an M1 transaction after M0 went last
        xfer(0, 1'b0, 4'hF, 32'h0000_0030, 32'h0, 32'hFFFF_FFCF, 1'b0, 2, 1'b1);
        mem_hang = 1;
        m1_req_i = 1; m1_we_i = 0; m1_be_i = 4'hF; m1_addr_i = 32'h0000_0050;
        cyc();
        @(negedge clk);
        check("pre_rst_busy", {31'h0, mem_req_o}, 32'h1);
        cyc();
        rst_i = 1;
        m1_req_i = 0;
        cyc();
        rst_i = 0;
        @(negedge clk);
        check("post_rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        check("post_rst_m1_ready", {31'h0, m1_ready_o}, 32'h0);
        mem_hang = 0;
        cyc();
        order.delete();
        fork
            xfer(0, 1'b0, 4'hF, 32'h0000_0060, 32'h0, 32'hFFFF_FF9F, 1'b0, 2, 1'b1);
            xfer(1, 1'b0, 4'hF, 32'h0000_0064, 32'h0, 32'hFFFF_FF9B, 1'b0, 2, 1'b1);
        join
        check("rst_tie_first", 32'(order[0]), 32'd0);
        check("rst_tie_second", 32'(order[1]), 32'd1);

        // M0 addr changes mid-BUSY while M1 waits; latched address must hold
        mem_wait = 4;
        order.delete();
        fork
            xfer(0, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 32'hFFFF_FFBF, 1'b0, 5, 1'b1);
            xfer(1, 1'b0, 4'hF, 32'h0000_0044, 32'h0, 32'hFFFF_FFBB, 1'b0, 5, 1'b1);
            begin
                cyc();
                cyc();
                m0_addr_i = 32'hDEAD_BEEC;
                @(negedge clk);
                check("hold_addr_a", mem_addr_o, 32'h0000_0040);
                @(negedge clk);
                check("hold_addr_b", mem_addr_o, 32'h0000_0040);
            end
        join
        mem_wait = 1;
        check("pend_first", 32'(order[0]), 32'd0);
        check("pend_second", 32'(order[1]), 32'd1);

        repeat (3) cyc();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
